// File: rtl/num_classifier_pkg.sv
// Shared types and sizing helpers for the number classifier.
package num_classifier_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHK_D,
    TRIAL,
    DONE
  } state_t;

  function automatic int k_width(input int width);
    return width / 2 + 1;
  endfunction

  function automatic int latency(input int width, input int trials);
    return 1 + (width + 1) * (1 + trials);
  endfunction

endpackage

// File: rtl/num_rem_seq.sv
// Restoring remainder unit: one load cycle, then WIDTH shift-subtract steps.
module num_rem_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH + 1);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH:0]   w_sh;
  logic             w_ge;
  logic             w_step;
  logic [WIDTH-1:0] w_rem_nxt;

  assign w_step = (r_cnt != '0) && (r_cnt != CNT_LOAD);
  assign w_sh   = {r_rem, r_q[WIDTH-1]};
  assign w_ge   = w_sh >= {1'b0, r_div};

  assign w_rem_nxt = w_ge ? WIDTH'(w_sh - {1'b0, r_div})
                          : w_sh[WIDTH-1:0];

  // Final step is combinational so the result is usable in the done cycle.
  assign done = (r_cnt == CW'(1));
  assign rem  = w_rem_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_q   <= '0;
      r_div <= '0;
      r_rem <= '0;
    end else if (start) begin
      r_cnt <= CNT_LOAD;
      r_q   <= dividend;
      r_div <= divisor;
      r_rem <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
      if (w_step) begin
        r_rem <= w_rem_nxt;
        r_q   <= r_q << 1;
      end
    end
  end

endmodule

// File: rtl/num_classifier.sv
// Sequential prime / divisible-by-DIV classifier around one shared
// remainder unit; trial division runs k = 2 .. while k*k <= n.
module num_classifier
  import num_classifier_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_p,
  output logic             out_d,
  output logic             busy
);

  localparam int KW = k_width(WIDTH);
  localparam int SW = WIDTH + 2;
  localparam logic [WIDTH-1:0] DIV_W = WIDTH'(DIV);

  if (DIV < 1 || DIV > (2 ** WIDTH) - 1) begin : g_bad_div
    $error("num_classifier: DIV out of range");
  end
  if (WIDTH < 4 || WIDTH > 16 || WIDTH % 2 != 0) begin : g_bad_w
    $error("num_classifier: WIDTH must be even, 4..16");
  end

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_n;
  logic [KW-1:0]    r_k;
  logic             r_p;
  logic             r_d;
  logic             r_kick;

  logic [KW-1:0]    w_k_nxt;
  logic [SW-1:0]    w_sq;
  logic             w_stop;
  logic             w_accept;
  logic             w_cont;
  logic             w_start;
  logic             w_done;
  logic             w_rem_zero;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_divisor;
  logic             w_set_d;
  logic             w_set_p;
  logic             w_p_val;

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == CHK_D) || (r_state == TRIAL);
  assign out_data  = r_n;
  assign out_p     = r_p;
  assign out_d     = r_d;

  // k*k is formed at WIDTH+2 bits so the stop test never wraps.
  assign w_k_nxt = (r_state == CHK_D) ? KW'(2) : r_k + KW'(1);
  assign w_sq    = SW'(w_k_nxt) * SW'(w_k_nxt);
  assign w_stop  = w_sq > SW'(r_n);

  assign w_rem_zero = (w_rem == '0);
  assign w_divisor  = r_kick ? DIV_W : WIDTH'(w_k_nxt);
  assign w_start    = r_kick | w_cont;

  num_rem_seq #(
    .WIDTH(WIDTH)
  ) u_rem (
    .clk     (clk),
    .rst     (rst),
    .start   (w_start),
    .dividend(r_n),
    .divisor (w_divisor),
    .done    (w_done),
    .rem     (w_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_cont      = 1'b0;
    w_set_d     = 1'b0;
    w_set_p     = 1'b0;
    w_p_val     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid && in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = CHK_D;
        end
      end
      CHK_D: begin
        if (w_done) begin
          w_set_d = 1'b1;
          if (r_n < WIDTH'(2)) begin
            w_set_p     = 1'b1;
            w_state_nxt = DONE;
          end else if (w_stop) begin
            w_set_p     = 1'b1;
            w_p_val     = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_cont      = 1'b1;
            w_state_nxt = TRIAL;
          end
        end
      end
      TRIAL: begin
        if (w_done) begin
          if (w_rem_zero) begin
            w_set_p     = 1'b1;
            w_state_nxt = DONE;
          end else if (w_stop) begin
            w_set_p     = 1'b1;
            w_p_val     = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_cont = 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n    <= '0;
      r_k    <= '0;
      r_p    <= 1'b0;
      r_d    <= 1'b0;
      r_kick <= 1'b0;
    end else begin
      r_kick <= w_accept;
      if (w_accept) begin
        r_n <= in_data;
        r_p <= 1'b0;
        r_d <= 1'b0;
      end
      if (w_set_d) r_d <= w_rem_zero;
      if (w_set_p) r_p <= w_p_val;
      if (w_cont)  r_k <= w_k_nxt;
    end
  end

endmodule

// File: tb/tb_num_classifier.sv
// Directed and exhaustive self-checking bench for num_classifier (WIDTH=8, DIV=3).
module tb_num_classifier;
  import num_classifier_pkg::*;

  localparam int W = 8;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_p;
  logic         out_d;
  logic         busy;

  int checks = 0;
  int failures = 0;

  num_classifier #(
    .WIDTH(W),
    .DIV  (D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_p    (out_p),
    .out_d    (out_d),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int n, output bit p,
                                output bit d, output int t);
    d = (n % D == 0);
    p = 1'b0;
    t = 0;
    if (n >= 2) begin
      p = 1'b1;
      for (int k = 2; k * k <= n; k++) begin
        t++;
        if (n % k == 0) begin
          p = 1'b0;
          break;
        end
      end
    end
  endfunction

  task automatic send(input logic [W-1:0] n);
    int g;
    g = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("in_ready_before_send", in_ready, 1);
    in_valid = 1'b1;
    in_data  = n;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~n;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic op(input string tag, input logic [W-1:0] n,
                    input bit ep, input bit ed, input int el);
    int lat;
    send(n);
    wait_out(lat);
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_p"}, out_p, ep);
    chk({tag, "_d"}, out_d, ed);
    chk({tag, "_data"}, out_data, n);
  endtask

  initial begin
    int g;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_out_d", out_d, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // hand-computed directed vectors
    op("n0", 8'd0, 1'b0, 1'b1, 10);
    op("n7", 8'd7, 1'b1, 1'b0, 19);
    op("n9", 8'd9, 1'b0, 1'b1, 28);
    op("n251", 8'd251, 1'b1, 1'b0, 136);
    op("n2", 8'd2, 1'b1, 1'b0, 10);
    op("n3", 8'd3, 1'b1, 1'b1, 10);
    op("n1", 8'd1, 1'b0, 1'b0, 10);
    @(posedge clk);
    #1;
    chk("n1_consumed_valid", out_valid, 0);
    chk("n1_consumed_ready", in_ready, 1);

    // back-pressure: result must hold while out_ready is low
    out_ready = 1'b0;
    op("n6", 8'd6, 1'b0, 1'b1, 19);
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("hold_n6", {in_ready, out_valid, out_p, out_d, out_data},
          {1'b0, 1'b1, 1'b0, 1'b1, 8'd6});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_valid", out_valid, 0);
    chk("release_ready", in_ready, 1);

    // reset while holding a result
    out_ready = 1'b0;
    op("n5", 8'd5, 1'b1, 1'b0, 19);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_in_done",
        {out_valid, out_p, out_d, busy, in_ready, out_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    // reset during trial division
    send(8'd251);
    repeat (30) @(posedge clk);
    #1;
    chk("trial_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_in_trial",
        {out_valid, busy, in_ready, out_p, out_d, out_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    op("n4_after_rst", 8'd4, 1'b0, 1'b0, 19);

    // exhaustive, back-to-back with in_valid held high
    g = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("ex_start_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = '0;
    for (int n = 0; n < 256; n++) begin
      bit ep;
      bit ed;
      int et;
      int lat;
      bit rdy_ok;
      model(n, ep, ed, et);
      @(posedge clk);
      #1;
      in_data  = W'(n + 1);
      in_valid = (n != 255);
      lat = 0;
      rdy_ok = 1'b1;
      while (out_valid !== 1'b1 && lat < 400) begin
        if (in_ready !== 1'b0) rdy_ok = 1'b0;
        @(posedge clk);
        #1;
        lat++;
      end
      if (in_ready !== 1'b0) rdy_ok = 1'b0;
      chk($sformatf("ex_lat_%0d", n), lat, latency(W, et));
      chk($sformatf("ex_p_%0d", n), out_p, ep);
      chk($sformatf("ex_d_%0d", n), out_d, ed);
      chk($sformatf("ex_data_%0d", n), out_data, n);
      chk($sformatf("ex_busy_ready_%0d", n), rdy_ok, 1);
      @(posedge clk);
      #1;
      chk($sformatf("ex_idle_ready_%0d", n), in_ready, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/num_classifier.md
Name: num_classifier

Overview:
- Sequential, parametrised successor to the 4-bit combinational number-property function.
- Accepts a WIDTH-bit unsigned number over a valid/ready handshake.
- Decides two flags and returns them with the number over a second valid/ready handshake:
  - p: the number is prime.
  - d: the number is divisible by DIV.
- Uses one shared multi-cycle remainder unit, so area stays flat as WIDTH grows.
- Sits between a number source (stimulus generator or upstream datapath) and a result consumer.

Parameters:
- WIDTH, 8, operand width in bits. Legal values: even numbers, 4..16.
- DIV, 3, divisor for the d flag. Legal range: 1..2^WIDTH-1 (elaboration check).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data holds a number to classify.
- in_ready  out  1  block can accept a number.
- in_data  in  WIDTH  number n, unsigned.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  WIDTH  echo of the accepted n.
- out_p  out  1  1 iff n is prime.
- out_d  out  1  1 iff n mod DIV == 0.
- busy  out  1  high in CHK_D or TRIAL.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE.
  - out_valid, out_data, out_p, out_d, busy all 0.
  - in_ready forced to 0 while rst is high.
  - Any in-flight operation is aborted and discarded.
- FSM states: IDLE, CHK_D, TRIAL, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch n, go to CHK_D, start the remainder unit on n mod DIV.
- Remainder operation timing:
  - Each operation occupies exactly WIDTH+1 cycles: 1 load plus WIDTH restoring shift-subtract steps.
  - The unit pulses done on its final cycle.
- CHK_D, on done:
  - Record d = (rem == 0). n = 0 gives d = 1.
  - If n < 2: p = 0, go to DONE.
  - Else: set k = 2, go to TRIAL.
- TRIAL, each step:
  - If k*k > n: p = 1, go to DONE. This test takes no extra cycle; it is evaluated in the same cycle the previous result is consumed.
  - Else: start n mod k. On done:
    - rem == 0: p = 0, go to DONE.
    - Otherwise: increment k and repeat.
- Widths:
  - k is WIDTH/2+1 bits.
  - k*k is computed at WIDTH+2 bits, so it cannot wrap. At WIDTH=16 the loop must terminate at k = 256.
- Latency, from the acceptance edge to out_valid high: L = 1 + (WIDTH+1)*(1+T), where T = number of trial remainders performed.
- DONE:
  - out_valid = 1, with out_data/out_p/out_d stable.
  - Outputs hold indefinitely while out_ready = 0.
  - On out_valid && out_ready: go to IDLE. in_ready rises the next cycle; no same-cycle turnaround.
- Classification rules:
  - 0 and 1 are never prime.
  - 2 and 3 are prime with T = 0.
- in_data is sampled only at the handshake. Later changes have no effect.
- in_valid while busy or in DONE is ignored (in_ready = 0).
- Reset asserted mid-operation: all outputs return to their reset values immediately, without waiting for clk.

Decomposition:
- Package num_classifier_pkg:
  - enum state_t {IDLE, CHK_D, TRIAL, DONE}.
  - localparam KW = WIDTH/2+1 helper, exposed as a function.
  - Latency helper function, used by the bench.
- Sub-module num_rem_seq:
  - Parameter WIDTH.
  - Ports: clk, rst, start, dividend, divisor, done, rem.
  - Restoring remainder, WIDTH+1 cycles per operation.
  - divisor = 0 never issued (DIV >= 1, k >= 2).

Test Plan (WIDTH=8, DIV=3, out_ready=1 unless stated):
- Reset then n=0 -> out_p=0, out_d=1, out_data=0, out_valid 10 cycles after acceptance.
- n=7 -> out_p=1, out_d=0, T=1 (k=2 rem 1; k=3 stops since 9>7), L=19.
- n=9 -> out_p=0, out_d=1, T=2 (k=3 rem 0), L=28.
- n=251 -> out_p=1, out_d=0, T=14 (k=2..15), L=136.
- Exhaustive 0..255 compared against a golden model:
  - Back-to-back in_valid, in_ready low throughout busy.
  - n=2 and n=3 have T=0; n=1 gives p=0, d=0.
- Robustness cases:
  - out_ready held 0 for 20 cycles with n=6 -> out_valid/out_p=0/out_d=1 stay stable; accepted only after release.
  - rst pulsed during TRIAL for n=251 -> out_valid=0 immediately; next accepted n=4 yields p=0, d=0.
